// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM states, register index width,
// and the opcode constants also used by the decoder.
package pipeline_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } hz_state_t;

   localparam logic [6:0] R_TYPE = 7'b0110011;
   localparam logic [6:0] I_TYPE = 7'b0010011;
   localparam logic [6:0] LW     = 7'b0000011;
   localparam logic [6:0] SW     = 7'b0100011;
   localparam logic [6:0] BR     = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] HALT   = 7'b1111111;

   // True when an ID source operand is actually read and names reg rd.
   function automatic logic reg_match(input logic [REG_ADDR_W-1:0] src,
                                      input logic [REG_ADDR_W-1:0] rd,
                                      input logic                  used);
      return used && (src == rd);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID/EX decode flags in, pipeline enables out.
// With HAZARD_PERF_EN defined, the stall/flush counters are carried too.
interface hazard_ctrl_if
   import pipeline_pkg::*;
#(
   parameter int DUMMY_W = 1
`ifdef HAZARD_PERF_EN
   , parameter int CNT_W = 32
`endif
);
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_use_rs1;
   logic                  id_use_rs2;
   logic                  id_halt;
   logic                  ex_memread;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  ex_redirect;
   logic                  pc_write;
   logic                  ifid_write;
   logic                  ifid_flush;
   logic                  idex_bubble;
   logic                  halted;
   logic                  drain_busy;
   logic [DUMMY_W-1:0]    spare;
`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0]      stall_cnt;
   logic [CNT_W-1:0]      flush_cnt;
`endif

`ifdef HAZARD_PERF_EN
   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
             ex_memread, ex_rd, ex_redirect, spare,
      input  pc_write, ifid_write, ifid_flush, idex_bubble, halted,
             drain_busy, stall_cnt, flush_cnt
   );
   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
             ex_memread, ex_rd, ex_redirect,
      output pc_write, ifid_write, ifid_flush, idex_bubble, halted,
             drain_busy, stall_cnt, flush_cnt
   );
`else
   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
             ex_memread, ex_rd, ex_redirect, spare,
      input  pc_write, ifid_write, ifid_flush, idex_bubble, halted,
             drain_busy
   );
   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
             ex_memread, ex_rd, ex_redirect,
      output pc_write, ifid_write, ifid_flush, idex_bubble, halted,
             drain_busy
   );
`endif

endinterface

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use comparator: a load in EX whose destination is a source the ID
// instruction reads. x0 never counts as a dependency.
module load_use_detect
   import pipeline_pkg::*;
(
   input  logic                  ex_memread_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   input  logic                  id_use_rs1_i,
   input  logic                  id_use_rs2_i,
   output logic                  hazard_o
);

   // Hazard when the EX load writes a non-zero reg that ID reads.
   always_comb begin
      hazard_o = ex_memread_i && (ex_rd_i != '0) &&
                 (reg_match(id_rs1_i, ex_rd_i, id_use_rs1_i) ||
                  reg_match(id_rs2_i, ex_rd_i, id_use_rs2_i));
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, redirect flushes and the
// halt drain FSM (RUN -> DRAIN -> HALTED, exit only through reset).
// Optional HAZARD_PERF_EN adds saturating stall/flush event counters.
module hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3
`ifdef HAZARD_PERF_EN
   , parameter int CNT_W = 32
`endif
)(
   input  logic          clk,
   input  logic          reset,
   hazard_ctrl_if.slave  hz
);

   localparam int CW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

   hz_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          lu_hazard;

   load_use_detect u_lud (
      .ex_memread_i (hz.ex_memread),
      .ex_rd_i      (hz.ex_rd),
      .id_rs1_i     (hz.id_rs1),
      .id_rs2_i     (hz.id_rs2),
      .id_use_rs1_i (hz.id_use_rs1),
      .id_use_rs2_i (hz.id_use_rs2),
      .hazard_o     (lu_hazard)
   );

   // State and drain counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state and pipeline controls. Redirect beats load-use, which beats
   // halt: a halt behind a redirect is wrong-path, a stalled halt retries.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      hz.pc_write    = 1'b1;
      hz.ifid_write  = 1'b1;
      hz.ifid_flush  = 1'b0;
      hz.idex_bubble = 1'b0;
      hz.halted      = 1'b0;
      hz.drain_busy  = 1'b0;
      if (reset) begin
         state_d        = RUN;
         cnt_d          = '0;
         hz.pc_write    = 1'b0;
         hz.ifid_write  = 1'b0;
         hz.ifid_flush  = 1'b1;
         hz.idex_bubble = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               if (hz.ex_redirect) begin
                  hz.ifid_flush  = 1'b1;
                  hz.idex_bubble = 1'b1;
               end else if (lu_hazard) begin
                  hz.pc_write    = 1'b0;
                  hz.ifid_write  = 1'b0;
                  hz.idex_bubble = 1'b1;
               end else if (hz.id_halt) begin
                  hz.pc_write    = 1'b0;
                  hz.ifid_write  = 1'b0;
                  hz.idex_bubble = 1'b1;
                  state_d        = DRAIN;
                  cnt_d          = CW'(DRAIN_CYCLES);
               end
            end
            DRAIN: begin
               // Only bubbles follow the halt, so redirects here are ignored.
               hz.pc_write    = 1'b0;
               hz.ifid_write  = 1'b0;
               hz.idex_bubble = 1'b1;
               hz.drain_busy  = 1'b1;
               cnt_d          = cnt_q - CW'(1);
               if (cnt_q <= CW'(1)) state_d = HALTED;
            end
            HALTED: begin
               hz.pc_write    = 1'b0;
               hz.ifid_write  = 1'b0;
               hz.idex_bubble = 1'b1;
               hz.halted      = 1'b1;
            end
            default: begin
               state_d = RUN;
               cnt_d   = '0;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   logic             stall_ev, flush_ev;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   // Counter events only exist in RUN, so the counters freeze once halted.
   always_comb begin
      stall_ev    = (state_q == RUN) && !hz.ex_redirect && lu_hazard;
      flush_ev    = (state_q == RUN) && hz.ex_redirect;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_ev && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_ev && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   // Saturating performance counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core; sits beside the IF/ID and ID/EX registers.
- Consumes decoded control flags (MemRead, Branch, JalrSel, Halt) and register indices from ID and EX.
- Drives PC/IF-ID write enables, ID/EX bubble insertion and IF/ID flush.
- Owns the halt-drain state machine that retires in-flight instructions before freezing the core.

Parameters:
- REG_ADDR_W, 5, register index width.
- DRAIN_CYCLES, 3, cycles after halt detection until all older instructions have left WB (EX, MEM, WB).
- CNT_W, 32, width of performance counters (optional feature only).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs1  in  REG_ADDR_W  rs1 index of instruction in ID.
- id_rs2  in  REG_ADDR_W  rs2 index of instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2 (R-type, store, branch).
- id_halt  in  1  Halt flag decoded in ID.
- ex_memread  in  1  MemRead of instruction in EX.
- ex_rd  in  REG_ADDR_W  destination of instruction in EX.
- ex_redirect  in  1  EX resolved taken branch, JAL or JALR; PC is being redirected.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  clear IF/ID to NOP on next edge.
- idex_bubble  out  1  load NOP controls into ID/EX on next edge.
- halted  out  1  core frozen; all pre-halt instructions retired.
- drain_busy  out  1  in DRAIN state.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- States: RUN, DRAIN, HALTED. Also a drain counter of width clog2(DRAIN_CYCLES+1). Both are registered.
- Reset: state=RUN, counter=0. While reset=1, outputs are: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, halted=0, drain_busy=0.
- Outputs are combinational from the current state and current inputs. Control takes effect at the next clock edge.
- Load-use hazard, all true in RUN: ex_memread=1, ex_rd!=0, and (ex_rd==id_rs1 with id_use_rs1) or (ex_rd==id_rs2 with id_use_rs2).
  - Response: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
  - Lasts exactly 1 cycle, because the load has moved to MEM on the next cycle.
- Redirect (ex_redirect=1 in RUN): ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1.
  - Redirect has priority over load-use stall; the stalled ID instruction is wrong-path.
- Halt entry, in RUN: id_halt=1, ex_redirect=0, no load-use hazard.
  - Response: idex_bubble=1, pc_write=0, ifid_write=0; next state DRAIN, counter loaded with DRAIN_CYCLES.
- Halt in ID with ex_redirect=1: halt is wrong-path and is ignored; flush as above, stay RUN.
- Halt in ID with load-use hazard: stall first. Halt is re-evaluated the following cycle.
- DRAIN: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, drain_busy=1.
  - Counter decrements each cycle.
  - When counter==1 the next state is HALTED, so DRAIN lasts DRAIN_CYCLES cycles.
  - ex_redirect is ignored in DRAIN: the halt is older than any instruction behind it, and only bubbles follow it.
- HALTED: pc_write=0, ifid_write=0, idex_bubble=1, halted=1. The only exit is reset.
- No load-use detection in DRAIN or HALTED.
- Reset asserted mid-DRAIN or in HALTED: state returns to RUN on the same edge.
- ex_rd==0 never causes a stall (x0).

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds outputs stall_cnt and flush_cnt, both CNT_W wide.
  - stall_cnt increments on each load-use stall cycle; flush_cnt increments on each redirect cycle in RUN.
  - Both saturate at all-ones, clear on reset, and freeze in HALTED.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package pipeline_pkg holds:
  - typedef enum logic [1:0] hz_state_t {RUN, DRAIN, HALTED};
  - REG_ADDR_W;
  - opcode constants (R_TYPE, I_TYPE, LW, SW, BR, JAL, JALR, HALT = 7'b1111111), reused by the decoder.
- One sub-module: load_use_detect, purely combinational compare logic.
- The FSM, counter and output muxing stay in hazard_ctrl.

Test Plan:
- lw x5 in EX (ex_memread=1, ex_rd=5), ID add with id_rs1=5, id_use_rs1=1 -> 1 cycle of pc_write=0, ifid_write=0, idex_bubble=1; next cycle all normal.
- ex_memread=1, ex_rd=0, id_rs1=0 -> no stall (pc_write=1, idex_bubble=0).
- Load-use hazard (ex_rd=7, id_rs2=7) plus ex_redirect=1 in the same cycle -> ifid_flush=1, idex_bubble=1, pc_write=1, no stall.
- id_halt=1, no hazards, DRAIN_CYCLES=3 -> drain_busy=1 for 3 cycles, then halted=1 stays high; pc_write=0 throughout.
- id_halt=1 with ex_redirect=1 -> flush, state stays RUN, halted never rises.
- Reset pulsed on the 2nd DRAIN cycle -> next cycle state RUN, halted=0, pc_write=1. With HAZARD_PERF_EN defined, stall_cnt=0 and flush_cnt=0 after reset.
